// File: rtl/cordic_vectoring.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_vectoring : multi-cycle CORDIC vectoring core producing atan(y/x) and
// sqrt(x^2+y^2); magnitude output enabled by macro CORDIC_VECTORING_MAGNITUDE_EN
// Rev 1.0
// ---------------------------------------------------------------------------
module cordic_vectoring #(
  parameter int FRACS           = 21,
  parameter int INTS            = 1,
  parameter int WIDTH           = INTS + FRACS + 1,
  parameter int ITERATIONS      = 15,
  parameter int ITERS_PER_STAGE = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic signed [WIDTH-1:0] angle,
  output logic signed [WIDTH-1:0] magnitude
);

  localparam int c_STAGES = ITERATIONS / ITERS_PER_STAGE;
  localparam int c_SW     = (c_STAGES > 1) ? $clog2(c_STAGES) : 1;
  localparam int c_XW     = WIDTH + 1;
  localparam logic [c_SW-1:0] c_LAST = c_SW'(c_STAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [c_SW-1:0]         r_stage;
  logic signed [c_XW-1:0]  r_x;
  logic signed [c_XW-1:0]  r_y;
  logic signed [WIDTH-1:0] r_z;
  logic                    r_zero;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic signed [WIDTH-1:0] r_angle;
  logic signed [WIDTH-1:0] r_mag;

  logic signed [c_XW-1:0]  w_xn;
  logic signed [c_XW-1:0]  w_yn;
  logic signed [c_XW-1:0]  w_xsh;
  logic signed [c_XW-1:0]  w_ysh;
  logic signed [WIDTH-1:0] w_zn;
  logic signed [WIDTH-1:0] w_mag;

  // atan(2^-k) in Q.21, rounded to nearest; beyond the table atan(x) ~= x
  function automatic logic signed [WIDTH-1:0] atan_lut(input int k);
    logic signed [31:0] v;
    case (k)
      0:       v = 32'sd1647099;
      1:       v = 32'sd972340;
      2:       v = 32'sd513757;
      3:       v = 32'sd260791;
      4:       v = 32'sd130902;
      5:       v = 32'sd65515;
      6:       v = 32'sd32765;
      7:       v = 32'sd16384;
      8:       v = 32'sd8192;
      9:       v = 32'sd4096;
      10:      v = 32'sd2048;
      11:      v = 32'sd1024;
      12:      v = 32'sd512;
      13:      v = 32'sd256;
      14:      v = 32'sd128;
      default: v = (k < 31) ? (32'sd2097152 >>> k) : 32'sd0;
    endcase
    return WIDTH'(v);
  endfunction

  // One clock worth of micro-rotations, chained combinationally
  always_comb begin
    w_xn  = r_x;
    w_yn  = r_y;
    w_zn  = r_z;
    w_xsh = '0;
    w_ysh = '0;
    for (int j = 0; j < ITERS_PER_STAGE; j++) begin
      w_xsh = w_xn >>> (int'(r_stage) * ITERS_PER_STAGE + j);
      w_ysh = w_yn >>> (int'(r_stage) * ITERS_PER_STAGE + j);
      if (!w_yn[c_XW-1]) begin
        w_xn = w_xn + w_ysh;
        w_yn = w_yn - w_xsh;
        w_zn = w_zn + atan_lut(int'(r_stage) * ITERS_PER_STAGE + j);
      end else begin
        w_xn = w_xn - w_ysh;
        w_yn = w_yn + w_xsh;
        w_zn = w_zn - atan_lut(int'(r_stage) * ITERS_PER_STAGE + j);
      end
    end
  end

`ifdef CORDIC_VECTORING_MAGNITUDE_EN
  // CORDIC gain compensation K = 0.607252935 in Q0.21
  localparam logic signed [21:0] c_K = 22'sd1273502;
  logic signed [c_XW+21:0] w_prod;
  assign w_prod = w_xn * c_K;
  assign w_mag  = WIDTH'(w_prod >>> FRACS);
`else
  assign w_mag = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_angle <= '0;
      r_mag   <= '0;
    end else if (clk_en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (x_in[WIDTH-1]) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_angle <= '0;
              r_mag   <= '0;
            end else begin
              r_x     <= {x_in[WIDTH-1], x_in};
              r_y     <= {y_in[WIDTH-1], y_in};
              r_z     <= '0;
              r_stage <= '0;
              // the rotation rule would sweep z all the way up for a zero vector
              r_zero  <= (x_in == '0) && (y_in == '0);
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_x <= w_xn;
          r_y <= w_yn;
          r_z <= w_zn;
          if (r_stage == c_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_angle <= r_zero ? '0 : w_zn;
            r_mag   <= w_mag;
          end else begin
            r_stage <= r_stage + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign angle     = r_angle;
  assign magnitude = r_mag;

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cordic_vectoring : directed vectors with scoreboard queue and done monitor
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cordic_vectoring;

  localparam int W   = 23;
  localparam int TOL = 160;
`ifdef CORDIC_VECTORING_MAGNITUDE_EN
  localparam bit MAG_EN = 1'b1;
`else
  localparam bit MAG_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                clk_en;
  logic                start;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic                busy;
  logic                done;
  logic                err;
  logic signed [W-1:0] angle;
  logic signed [W-1:0] magnitude;

  typedef struct {
    int angle;
    int mag;
    bit err;
    int atol;
    int mtol;
    bit chk_mag;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  int   n_chk  = 0;
  int   n_pass = 0;

  cordic_vectoring dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .angle     (angle),
    .magnitude (magnitude)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp_v,
                       input longint tol);
    longint d;
    d = act - exp_v;
    if (d < 0) d = -d;
    n_chk++;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp_v, tol);
  endtask

  // Latency is counted in edges after the edge that samples start.
  task automatic issue(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                       input int ea, input int em, input bit eerr, input bit cm,
                       input int elat, input int gate, input bit poke);
    exp_t e;
    int   lat;
    e.angle   = ea;
    e.mag     = MAG_EN ? em : 0;
    e.err     = eerr;
    e.atol    = eerr ? 0 : TOL;
    e.mtol    = (MAG_EN && !eerr) ? TOL : 0;
    e.chk_mag = cm;
    q.push_back(e);
    x_in  = x;
    y_in  = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        check("busy_run", busy, 1, 0);
        if (poke) begin
          start = 1'b1;
          x_in  = -23'sd1048576;
        end
        if (gate > 0) begin
          clk_en = 1'b0;
          repeat (gate) @(posedge clk);
          #1;
          clk_en = 1'b1;
          lat += gate;
        end
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", lat, elat, 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: done=1 with no outstanding request");
      end else begin
        e_m = q.pop_front();
        check("angle", angle, e_m.angle, e_m.atol);
        check("err", err, e_m.err, 0);
        if (e_m.chk_mag) check("magnitude", magnitude, e_m.mag, e_m.mtol);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset  = 1'b0;
    clk_en = 1'b1;
    start  = 1'b1;
    x_in   = 23'sd1048576;
    y_in   = 23'sd1048576;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_err", err, 0, 0);
    check("rst_angle", angle, 0, 0);
    check("rst_magnitude", magnitude, 0, 0);

    // first start lands on the first edge after release
    reset = 1'b1;
    issue(23'sd1048576, 23'sd1048576, 1647099, 1482910, 1'b0, 1'b1, 3, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("angle_hold", angle, 1647099, TOL);

    issue(23'sd1048576, -23'sd524288, -972340, 1172357, 1'b0, 1'b1, 3, 0, 1'b0);
    issue(23'sd0, 23'sd1048576, 3294199, 1048576, 1'b0, 1'b1, 3, 0, 1'b0);
    issue(23'sd4194303, 23'sd0, 0, 0, 1'b0, 1'b0, 3, 0, 1'b0);
    issue(-23'sd1048576, 23'sd209715, 0, 0, 1'b1, 1'b1, 0, 0, 1'b0);
    issue(23'sd0, 23'sd0, 0, 0, 1'b0, 1'b1, 3, 0, 1'b0);
    // clk_en low for 4 cycles after first RUN edge, with a stray start pulse
    issue(23'sd1048576, 23'sd1048576, 1647099, 1482910, 1'b0, 1'b1, 7, 4, 1'b1);
    issue(23'sd1048576, -23'sd524288, -972340, 1172357, 1'b0, 1'b1, 3, 0, 1'b0);

    // reset pulse around RUN edge 2 aborts without a done pulse
    x_in  = 23'sd1048576;
    y_in  = 23'sd1048576;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0, 0);
    check("abort_done", done, 0, 0);
    check("abort_angle", angle, 0, 0);
    check("abort_magnitude", magnitude, 0, 0);
    check("abort_err", err, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    issue(23'sd1048576, 23'sd1048576, 1647099, 1482910, 1'b0, 1'b1, 3, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("pending_results", q.size(), 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
